// File: rtl/float_to_fixed_param.sv
// Multi-cycle parametrised float-to-fixed converter with round-half-even,
// saturation and NaN/Inf handling behind the Begin_FSM_FF / ACK_FF handshake.
module float_to_fixed_param #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int FIX_W  = 32,
    parameter int FRAC_W = 26
) (
    input  logic                   CLK,
    input  logic                   RST_FF,
    input  logic                   Begin_FSM_FF,
    input  logic [EXP_W+MAN_W:0]   F,
    output logic                   ACK_FF,
    output logic                   BUSY,
    output logic [FIX_W-1:0]       RESULT,
    output logic                   OVF,
    output logic                   INV
);

    localparam int FLT_W   = 1 + EXP_W + MAN_W;
    localparam int BIAS    = (1 << (EXP_W - 1)) - 1;
    localparam int INT_W   = FIX_W - 1 - FRAC_W;
    localparam int RCLAMP  = MAN_W + 3;
    localparam int SH_W    = (MAN_W + 1 > FIX_W) ? MAN_W + 1 : FIX_W;
    localparam int CNT_MAX = (RCLAMP > FIX_W) ? RCLAMP : FIX_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [FIX_W-1:0] FIX_MIN = {1'b1, {(FIX_W-1){1'b0}}};
    localparam logic [FIX_W-1:0] FIX_MAX = {1'b0, {(FIX_W-1){1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_SHIFT,
        S_ROUND,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [FLT_W-1:0]   r_f;
    logic               r_s;
    logic               r_inv;
    logic               r_ovf;
    logic               r_min;
    logic               r_left;
    logic               r_g;
    logic               r_st;
    logic [SH_W-1:0]    r_sh;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_sign;
    logic [EXP_W-1:0]   w_e;
    logic [MAN_W-1:0]   w_m;
    logic signed [31:0] w_unb;
    logic signed [31:0] w_k;
    logic signed [31:0] w_kneg;
    logic               w_e_max;
    logic               w_e_zero;
    logic               w_is_nan;
    logic               w_is_inf;
    logic               w_is_min;
    logic               w_range_ovf;
    logic [CNT_W-1:0]   w_cnt;

    logic               w_inc;
    logic [SH_W:0]      w_mag;
    logic               w_carry_ovf;
    logic [FIX_W-1:0]   w_fix;
    logic [FIX_W-1:0]   w_res;
    logic               w_ovf_o;

    assign w_sign = r_f[FLT_W-1];
    assign w_e    = r_f[FLT_W-2:MAN_W];
    assign w_m    = r_f[MAN_W-1:0];

    always_comb begin
        w_unb       = $signed(32'(w_e)) - BIAS;
        w_k         = w_unb + FRAC_W - MAN_W;
        w_kneg      = -w_k;
        w_e_max     = &w_e;
        w_e_zero    = ~|w_e;
        w_is_nan    = w_e_max & (|w_m);
        w_is_inf    = w_e_max & ~(|w_m);
        // The most negative representable value is exact and must not flag OVF.
        w_is_min    = ~w_e_max & w_sign & ~(|w_m) & (w_unb == INT_W);
        w_range_ovf = ~w_e_max & ~w_e_zero & (w_unb >= INT_W) & ~w_is_min;
        w_cnt       = '0;
        if (!w_e_max && !w_e_zero && (w_unb < INT_W)) begin
            if (w_k >= 0)
                w_cnt = CNT_W'(w_k);
            else if (w_kneg > RCLAMP)
                w_cnt = CNT_W'(RCLAMP);
            else
                w_cnt = CNT_W'(w_kneg);
        end
    end

    always_comb begin
        w_inc       = r_g & (r_st | r_sh[0]);
        w_mag       = {1'b0, r_sh} + (SH_W+1)'(w_inc);
        w_carry_ovf = |(w_mag >> (FIX_W - 1));
        w_fix       = FIX_W'(w_mag);
        w_res       = '0;
        w_ovf_o     = 1'b0;
        if (r_inv) begin
            w_res = '0;
        end else if (r_min) begin
            w_res = FIX_MIN;
        end else if (r_ovf || w_carry_ovf) begin
            w_ovf_o = 1'b1;
            w_res   = r_s ? FIX_MIN : FIX_MAX;
        end else begin
            w_res = r_s ? -w_fix : w_fix;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (Begin_FSM_FF) w_next = S_DECODE;
            S_DECODE: w_next = (w_cnt != '0) ? S_SHIFT : S_ROUND;
            S_SHIFT:  if (r_cnt == CNT_W'(1)) w_next = S_ROUND;
            S_ROUND:  w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ACK_FF = (r_state == S_DONE);
        BUSY   = (r_state != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RST_FF) begin
        if (!RST_FF)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge CLK or negedge RST_FF) begin
        if (!RST_FF) begin
            r_f    <= '0;
            r_s    <= 1'b0;
            r_inv  <= 1'b0;
            r_ovf  <= 1'b0;
            r_min  <= 1'b0;
            r_left <= 1'b0;
            r_g    <= 1'b0;
            r_st   <= 1'b0;
            r_sh   <= '0;
            r_cnt  <= '0;
            RESULT <= '0;
            OVF    <= 1'b0;
            INV    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Begin_FSM_FF)
                        r_f <= F;
                end
                S_DECODE: begin
                    r_s    <= w_sign;
                    r_inv  <= w_is_nan;
                    r_ovf  <= w_is_inf | w_range_ovf;
                    r_min  <= w_is_min;
                    r_left <= (w_k >= 0);
                    r_g    <= 1'b0;
                    r_st   <= 1'b0;
                    r_cnt  <= w_cnt;
                    if (w_e_max || w_e_zero || w_range_ovf || w_is_min)
                        r_sh <= '0;
                    else
                        r_sh <= SH_W'({1'b1, w_m});
                end
                S_SHIFT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_left) begin
                        r_sh <= {r_sh[SH_W-2:0], 1'b0};
                    end else begin
                        r_sh <= r_sh >> 1;
                        r_g  <= r_sh[0];
                        r_st <= r_st | r_g;
                    end
                end
                S_ROUND: begin
                    RESULT <= w_res;
                    OVF    <= w_ovf_o;
                    INV    <= r_inv;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_float_to_fixed_param.sv
// Bench for float_to_fixed_param: vector table through a scoreboard on the
// default instance, handshake/reset sequences, and a half-precision instance.
module tb_float_to_fixed_param;

    logic        CLK = 1'b0;
    logic        RST_FF;
    logic        Begin_FSM_FF;
    logic [31:0] F;
    logic        ACK_FF;
    logic        BUSY;
    logic [31:0] RESULT;
    logic        OVF;
    logic        INV;

    logic        h_begin;
    logic [15:0] h_f;
    logic        h_ack;
    logic        h_busy;
    logic [15:0] h_result;
    logic        h_ovf;
    logic        h_inv;

    always #5 CLK = ~CLK;

    float_to_fixed_param dut (
        .CLK          (CLK),
        .RST_FF       (RST_FF),
        .Begin_FSM_FF (Begin_FSM_FF),
        .F            (F),
        .ACK_FF       (ACK_FF),
        .BUSY         (BUSY),
        .RESULT       (RESULT),
        .OVF          (OVF),
        .INV          (INV)
    );

    float_to_fixed_param #(
        .EXP_W  (5),
        .MAN_W  (10),
        .FIX_W  (16),
        .FRAC_W (8)
    ) dut_h (
        .CLK          (CLK),
        .RST_FF       (RST_FF),
        .Begin_FSM_FF (h_begin),
        .F            (h_f),
        .ACK_FF       (h_ack),
        .BUSY         (h_busy),
        .RESULT       (h_result),
        .OVF          (h_ovf),
        .INV          (h_inv)
    );

    typedef struct {
        logic [31:0] f;
        logic [31:0] res;
        logic        ovf;
        logic        inv;
        int          cnt;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        inv;
        int          cnt;
        int          acc;
        int          id;
    } exp_t;

    vec_t tbl[18];
    vec_t htbl[3];
    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
        end
    endtask

    // Scoreboard consumer: every ACK pops one expectation
    always @(negedge CLK) begin
        exp_t e;
        if (ACK_FF === 1'b1) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_ack: got ACK at cycle %0d expected none", cyc);
            end else begin
                e = sbq.pop_front();
                chk($sformatf("id%0d_result", e.id), RESULT, e.res);
                chk($sformatf("id%0d_ovf", e.id), OVF, e.ovf);
                chk($sformatf("id%0d_inv", e.id), INV, e.inv);
                chk($sformatf("id%0d_latency", e.id), cyc - e.acc + 1, 3 + e.cnt);
                chk($sformatf("id%0d_busy_at_ack", e.id), BUSY, 1);
            end
        end
    end

    task automatic wait_drain(input string nm);
        int k = 0;
        while (sbq.size() != 0 && k < 200) begin
            @(negedge CLK);
            k++;
        end
        if (sbq.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got %0d pending expected 0", nm, sbq.size());
            sbq.delete();
        end
        @(negedge CLK);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        exp_t e;
        F            = v.f;
        Begin_FSM_FF = 1'b1;
        @(posedge CLK);
        #1;
        e = '{res: v.res, ovf: v.ovf, inv: v.inv, cnt: v.cnt, acc: cyc, id: id};
        sbq.push_back(e);
        Begin_FSM_FF = 1'b0;
        wait_drain($sformatf("id%0d", id));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   a;
        int   k;

        tbl[0]  = '{32'h3F800000, 32'h04000000, 1'b0, 1'b0, 3};
        tbl[1]  = '{32'hBF800000, 32'hFC000000, 1'b0, 1'b0, 3};
        tbl[2]  = '{32'h41FC0000, 32'h7E000000, 1'b0, 1'b0, 7};
        tbl[3]  = '{32'h42C80000, 32'h7FFFFFFF, 1'b1, 1'b0, 0};
        tbl[4]  = '{32'hC2C80000, 32'h80000000, 1'b1, 1'b0, 0};
        tbl[5]  = '{32'hC2000000, 32'h80000000, 1'b0, 1'b0, 0};
        tbl[6]  = '{32'h32000000, 32'h00000000, 1'b0, 1'b0, 24};
        tbl[7]  = '{32'h32400000, 32'h00000001, 1'b0, 1'b0, 24};
        tbl[8]  = '{32'h32C00000, 32'h00000002, 1'b0, 1'b0, 23};
        tbl[9]  = '{32'hB2C00000, 32'hFFFFFFFE, 1'b0, 1'b0, 23};
        tbl[10] = '{32'h7FC00000, 32'h00000000, 1'b0, 1'b1, 0};
        tbl[11] = '{32'hFF800000, 32'h80000000, 1'b1, 1'b0, 0};
        tbl[12] = '{32'h7F800000, 32'h7FFFFFFF, 1'b1, 1'b0, 0};
        tbl[13] = '{32'h00000001, 32'h00000000, 1'b0, 1'b0, 0};
        tbl[14] = '{32'h00800000, 32'h00000000, 1'b0, 1'b0, 26};
        tbl[15] = '{32'h41FFFFFF, 32'h7FFFFF80, 1'b0, 1'b0, 7};
        tbl[16] = '{32'h3F000000, 32'h02000000, 1'b0, 1'b0, 2};
        tbl[17] = '{32'h42000000, 32'h7FFFFFFF, 1'b1, 1'b0, 0};

        htbl[0] = '{32'h3C00, 32'h0100, 1'b0, 1'b0, 2};
        htbl[1] = '{32'hBE00, 32'hFE80, 1'b0, 1'b0, 2};
        htbl[2] = '{32'h5800, 32'h7FFF, 1'b1, 1'b0, 0};

        RST_FF       = 1'b0;
        Begin_FSM_FF = 1'b0;
        F            = '0;
        h_begin      = 1'b0;
        h_f          = '0;
        repeat (3) @(negedge CLK);
        chk("reset_result", RESULT, 0);
        chk("reset_ovf", OVF, 0);
        chk("reset_inv", INV, 0);
        chk("reset_ack", ACK_FF, 0);
        chk("reset_busy", BUSY, 0);
        chk("reset_h_result", h_result, 0);
        RST_FF = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 18; i++)
            run_vec(tbl[i], i);

        // Begin held high: second start re-triggers on the IDLE after DONE; F change after capture ignored
        F            = 32'h3F800000;
        Begin_FSM_FF = 1'b1;
        @(posedge CLK);
        #1;
        a = cyc;
        e = '{res: 32'h04000000, ovf: 1'b0, inv: 1'b0, cnt: 3, acc: a, id: 100};
        sbq.push_back(e);
        e = '{res: 32'hFC000000, ovf: 1'b0, inv: 1'b0, cnt: 3, acc: a + 7, id: 101};
        sbq.push_back(e);
        @(negedge CLK);
        F = 32'hBF800000;
        while (cyc < a + 7) @(negedge CLK);
        Begin_FSM_FF = 1'b0;
        wait_drain("held_begin");

        // Start pulse during SHIFT must be ignored
        F            = 32'h3F800000;
        Begin_FSM_FF = 1'b1;
        @(posedge CLK);
        #1;
        e = '{res: 32'h04000000, ovf: 1'b0, inv: 1'b0, cnt: 3, acc: cyc, id: 200};
        sbq.push_back(e);
        Begin_FSM_FF = 1'b0;
        repeat (2) @(negedge CLK);
        F            = 32'h42C80000;
        Begin_FSM_FF = 1'b1;
        @(negedge CLK);
        Begin_FSM_FF = 1'b0;
        wait_drain("ignored_start");
        repeat (8) @(negedge CLK);
        chk("idle_after_ignored_start", BUSY, 0);

        // Asynchronous reset mid-SHIFT aborts without ACK
        F            = 32'h41FC0000;
        Begin_FSM_FF = 1'b1;
        @(posedge CLK);
        #1;
        e = '{res: 32'h7E000000, ovf: 1'b0, inv: 1'b0, cnt: 7, acc: cyc, id: 300};
        sbq.push_back(e);
        Begin_FSM_FF = 1'b0;
        repeat (3) @(negedge CLK);
        chk("pre_reset_busy", BUSY, 1);
        RST_FF = 1'b0;
        #1;
        chk("midrst_result", RESULT, 0);
        chk("midrst_ovf", OVF, 0);
        chk("midrst_inv", INV, 0);
        chk("midrst_ack", ACK_FF, 0);
        chk("midrst_busy", BUSY, 0);
        sbq.delete();
        repeat (10) @(negedge CLK);
        RST_FF = 1'b1;
        @(negedge CLK);
        run_vec(tbl[2], 301);
        run_vec(tbl[9], 302);

        // Half-precision parameter set
        for (int i = 0; i < 3; i++) begin
            h_f     = htbl[i].f[15:0];
            h_begin = 1'b1;
            @(posedge CLK);
            #1;
            a       = cyc;
            h_begin = 1'b0;
            k       = 0;
            @(negedge CLK);
            while (h_ack !== 1'b1 && k < 100) begin
                @(negedge CLK);
                k++;
            end
            if (h_ack !== 1'b1) begin
                n_cmp++;
                n_err++;
                $display("FAIL half%0d_timeout: got no ACK expected ACK", i);
            end else begin
                chk($sformatf("half%0d_result", i), h_result, htbl[i].res[15:0]);
                chk($sformatf("half%0d_ovf", i), h_ovf, htbl[i].ovf);
                chk($sformatf("half%0d_inv", i), h_inv, htbl[i].inv);
                chk($sformatf("half%0d_latency", i), cyc - a + 1, 3 + htbl[i].cnt);
            end
            @(negedge CLK);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/float_to_fixed_param.md
Name: float_to_fixed_param

Overview:
- Parametrised, multi-cycle IEEE-754-style float-to-fixed converter; successor to the fixed single-precision converter feeding the CORDIC natural-log datapath.
- Generalised in float format (exponent/mantissa width) and fixed format (total/fractional width).
- Adds round-half-even, saturation, overflow/invalid flags and special-value handling.
- Uses the same Begin_FSM_FF / ACK_FF start/done handshake as the other conversion blocks.

Parameters:
- EXP_W, 8, float exponent width
- MAN_W, 23, float stored-mantissa width (hidden bit implied); float width FLT_W = 1+EXP_W+MAN_W
- FIX_W, 32, fixed output width, two's complement
- FRAC_W, 26, fractional bits of fixed output (Q(FIX_W-1-FRAC_W).FRAC_W)

Ports:
- CLK  in  1  system clock
- RST_FF  in  1  asynchronous, active-low reset
- Begin_FSM_FF  in  1  start; sampled only in IDLE
- F  in  FLT_W  float operand; captured on accepted start
- ACK_FF  out  1  one-cycle done pulse
- BUSY  out  1  high from accepted start through DONE inclusive
- RESULT  out  FIX_W  fixed result; held between conversions
- OVF  out  1  saturation occurred (Inf or out-of-range); valid with RESULT
- INV  out  1  input was NaN; valid with RESULT

Behaviour:
- Reset (RST_FF=0, asynchronous): state IDLE; ACK_FF=0, BUSY=0, RESULT=0, OVF=0, INV=0; all internal registers cleared. Reset mid-conversion aborts it; no ACK is produced.
- Decode: s=F[FLT_W-1], e=F[FLT_W-2:MAN_W], m=F[MAN_W-1:0], BIAS=2^(EXP_W-1)-1.
  - Significand S={1,m}, weight 2^-MAN_W.
  - Shift k = e-BIAS+FRAC_W-MAN_W (signed).
- States:
  - IDLE: BUSY=0. On Begin_FSM_FF=1, latch F and go to DECODE.
  - DECODE (1 cycle): classify the operand.
    - NaN (e all ones, m!=0): INV=1, value 0, go to ROUND_SAT.
    - Inf (e all ones, m=0): OVF=1, go to ROUND_SAT.
    - Zero or denormal (e=0): value 0.
    - Range: e-BIAS >= FIX_W-1-FRAC_W gives OVF=1, except the exact value -2^(FIX_W-1-FRAC_W) (s=1, m=0, e-BIAS=FIX_W-1-FRAC_W), which gives 0x..80..0 with OVF=0.
    - Otherwise load S into the shift register, clear guard/sticky, and set cnt=|k|.
    - Right-shift count is clamped to MAN_W+3; anything beyond that is pure sticky.
    - Go to SHIFT if cnt>0, else ROUND_SAT.
  - SHIFT: one bit per cycle; cnt decrements each cycle; exit to ROUND_SAT when cnt reaches 1.
    - Left shift: zero fill.
    - Right shift: LSB goes to guard; the old guard ORs into sticky.
  - ROUND_SAT (1 cycle):
    - Rounding: round half-even on the magnitude (increment if guard & (sticky | lsb)).
    - Saturation: a rounding carry past 2^(FIX_W-1) also saturates with OVF=1.
    - Sign: negate if s=1.
    - Saturated outputs: 2^(FIX_W-1)-1 for s=0, -2^(FIX_W-1) for s=1; NaN gives 0.
    - Register RESULT/OVF/INV.
  - DONE (1 cycle): ACK_FF=1, BUSY=1. Next state IDLE.
- Latency from the edge that accepts the start to the ACK_FF high cycle: 3+cnt cycles, where cnt=0 for special, zero and saturated operands.
- Begin_FSM_FF while BUSY is ignored. Holding Begin_FSM_FF high re-triggers on the IDLE cycle after DONE, so back-to-back throughput is 4+cnt cycles.
- F changes after capture have no effect.
- RESULT, OVF and INV change only on entry to DONE (or on reset).

Test Plan:
- Defaults, F=0x3F800000 (1.0) -> after 3 SHIFT cycles, ACK at 6th cycle after start: RESULT=0x04000000, OVF=0, INV=0.
- F=0xBF800000 (-1.0) -> RESULT=0xFC000000. F=0x41FC0000 (31.5) -> RESULT=0x7E000000.
- Saturation:
  - F=0x42C80000 (100.0) -> RESULT=0x7FFFFFFF, OVF=1.
  - F=0xC2C80000 -> RESULT=0x80000000, OVF=1.
  - F=0xC2000000 (-32.0) -> RESULT=0x80000000, OVF=0.
- Rounding:
  - F=0x32000000 (2^-27, half LSB, even) -> RESULT=0.
  - F=0x32400000 (0.75 LSB) -> RESULT=1.
  - F=0x32C00000 (1.5 LSB) -> RESULT=2.
- Specials:
  - F=0x7FC00000 -> RESULT=0, INV=1.
  - F=0xFF800000 -> RESULT=0x80000000, OVF=1.
  - F=0x00000001 -> RESULT=0.
- Handshake/reset:
  - Pulse Begin_FSM_FF during SHIFT -> ignored.
  - Drop RST_FF mid-SHIFT -> all outputs 0 immediately; no ACK; the next start converts normally.
  - Parameter set EXP_W=5, MAN_W=10, FIX_W=16, FRAC_W=8: F=0x3C00 -> RESULT=0x0100.
